// File: rtl/exe_muldiv_unit_pkg.sv
// Shared execute-stage definitions: muldiv command codes, FSM state encoding
// and a sizing helper for the iteration counter.
package exe_muldiv_unit_pkg;

   // Placed above the existing ALU command codes so the encodings never collide.
   localparam logic [3:0] EXE_MUL = 4'hC;
   localparam logic [3:0] EXE_DIV = 4'hD;
   localparam logic [3:0] EXE_REM = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   // One extra bit so the counter can represent WIDTH without wrapping.
   function automatic int count_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift registers, adder/subtractor and iteration counter for the
// shift-add multiplier and the restoring divider.
module muldiv_datapath
   import exe_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = count_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             last_step,
   output logic [WIDTH-1:0] prod_next,
   output logic [WIDTH-1:0] quot_next,
   output logic [WIDTH-1:0] rem_next
);

   // reg_a: multiplicand (shifts left) or divisor (static)
   // reg_b: multiplier (shifts right) or dividend/quotient (shifts left)
   // reg_acc: product accumulator or partial remainder
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] reg_acc;
   logic [CNT_W-1:0] count;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   lhs;
   logic [WIDTH:0]   rhs;
   logic [WIDTH:0]   sum;
   logic             quot_bit;

   always_comb begin
      shifted = {reg_acc, reg_b[WIDTH-1]};
      if (div_sel) begin
         // Subtract via two's complement: shifted + ~divisor + 1.
         lhs = shifted;
         rhs = ~{1'b0, reg_a};
      end else begin
         lhs = {1'b0, reg_acc};
         rhs = reg_b[0] ? {1'b0, reg_a} : '0;
      end
      sum       = lhs + rhs + {{WIDTH{1'b0}}, div_sel};
      // Partial remainder stays below the divisor, so bit WIDTH is a clean borrow.
      quot_bit  = ~sum[WIDTH];
      prod_next = sum[WIDTH-1:0];
      quot_next = {reg_b[WIDTH-2:0], quot_bit};
      rem_next  = quot_bit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

   assign last_step = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_a   <= '0;
         reg_b   <= '0;
         reg_acc <= '0;
         count   <= '0;
      end else if (load) begin
         reg_a   <= div_sel ? op_b : op_a;
         reg_b   <= div_sel ? op_a : op_b;
         reg_acc <= '0;
         count   <= '0;
      end else if (step) begin
         if (div_sel) begin
            reg_acc <= rem_next;
            reg_b   <= quot_next;
         end else begin
            reg_acc <= prod_next;
            reg_a   <= {reg_a[WIDTH-2:0], 1'b0};
            reg_b   <= {1'b0, reg_b[WIDTH-1:1]};
         end
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative unsigned MUL/DIV/REM engine for the EXE stage: stalls the front
// of the pipeline while computing and retires a one-cycle result bundle.
module exe_muldiv_unit
   import exe_muldiv_unit_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int FUNC_W = 4,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [FUNC_W-1:0] exe_cmd_i,
   input  logic [WIDTH-1:0]  val1_i,
   input  logic [WIDTH-1:0]  val2_i,
   input  logic [REG_W-1:0]  dest_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [WIDTH-1:0]  result_o,
   output logic [REG_W-1:0]  dest_o,
   output logic              wb_en_o,
   output muldiv_state_e     fsm_state
);

   muldiv_state_e     state;
   muldiv_state_e     state_next;

   logic [FUNC_W-1:0] cmd_q;
   logic [REG_W-1:0]  dest_q;
   logic [REG_W-1:0]  dest_out;
   logic [WIDTH-1:0]  result_q;

   logic              is_mul;
   logic              is_div;
   logic              is_rem;
   logic              accept;
   logic              dp_load;
   logic              dp_step;
   logic              div_sel;
   logic              last_step;
   logic              capture;
   logic              done;
   logic [WIDTH-1:0]  capture_val;
   logic [REG_W-1:0]  capture_dest;
   logic [WIDTH-1:0]  prod_next;
   logic [WIDTH-1:0]  quot_next;
   logic [WIDTH-1:0]  rem_next;

   assign is_mul = (exe_cmd_i == FUNC_W'(EXE_MUL));
   assign is_div = (exe_cmd_i == FUNC_W'(EXE_DIV));
   assign is_rem = (exe_cmd_i == FUNC_W'(EXE_REM));
   assign accept = start_i && !flush_i && (is_mul || is_div || is_rem);

   always_comb begin
      state_next   = state;
      dp_load      = 1'b0;
      dp_step      = 1'b0;
      div_sel      = (state == ST_DIV);
      capture      = 1'b0;
      capture_val  = '0;
      capture_dest = dest_q;
      busy_o       = 1'b0;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            div_sel      = is_div || is_rem;
            capture_dest = dest_i;
            if (accept) begin
               // Freeze upstream in the same cycle the command is taken.
               busy_o = 1'b1;
               if (is_mul) begin
                  dp_load    = 1'b1;
                  state_next = ST_MUL;
               end else if (val2_i != '0) begin
                  dp_load    = 1'b1;
                  state_next = ST_DIV;
               end else begin
                  capture     = 1'b1;
                  capture_val = is_div ? '1 : val1_i;
                  state_next  = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_next = ST_IDLE;
            end else begin
               dp_step = 1'b1;
               if (last_step) begin
                  capture     = 1'b1;
                  capture_val = prod_next;
                  state_next  = ST_DONE;
               end
            end
         end
         ST_DIV: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_next = ST_IDLE;
            end else begin
               dp_step = 1'b1;
               if (last_step) begin
                  capture     = 1'b1;
                  capture_val = (cmd_q == FUNC_W'(EXE_REM)) ? rem_next : quot_next;
                  state_next  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // busy_o stays low so the held instruction advances as we retire.
            done       = !flush_i;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cmd_q    <= '0;
         dest_q   <= '0;
         dest_out <= '0;
         result_q <= '0;
      end else begin
         state <= state_next;
         if (dp_load) begin
            cmd_q  <= exe_cmd_i;
            dest_q <= dest_i;
         end
         if (capture) begin
            result_q <= capture_val;
            dest_out <= capture_dest;
         end
      end
   end

   muldiv_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk       (clk),
      .reset     (reset),
      .load      (dp_load),
      .step      (dp_step),
      .div_sel   (div_sel),
      .op_a      (val1_i),
      .op_b      (val2_i),
      .last_step (last_step),
      .prod_next (prod_next),
      .quot_next (quot_next),
      .rem_next  (rem_next)
   );

   assign done_o    = done;
   assign wb_en_o   = done;
   assign result_o  = result_q;
   assign dest_o    = dest_out;
   assign fsm_state = state;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: latency, results, divide-by-zero,
// flush/reset abort and start_i filtering.
module tb_exe_muldiv_unit;
   import exe_muldiv_unit_pkg::*;

   logic          clk;
   logic          reset;
   logic          start_i;
   logic [3:0]    exe_cmd_i;
   logic [31:0]   val1_i;
   logic [31:0]   val2_i;
   logic [4:0]    dest_i;
   logic          flush_i;
   logic          busy_o;
   logic          done_o;
   logic [31:0]   result_o;
   logic [4:0]    dest_o;
   logic          wb_en_o;
   muldiv_state_e fsm_state;

   int errors = 0;
   int checks = 0;

   exe_muldiv_unit #(.WIDTH(32), .FUNC_W(4), .REG_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start_i),
      .exe_cmd_i (exe_cmd_i),
      .val1_i    (val1_i),
      .val2_i    (val2_i),
      .dest_i    (dest_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .dest_o    (dest_o),
      .wb_en_o   (wb_en_o),
      .fsm_state (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drivers: callers sit just after a negedge; start_op leaves them in cycle 1.
   task automatic start_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] dst, output logic busy0);
      exe_cmd_i = cmd; val1_i = a; val2_i = b; dest_i = dst; start_i = 1'b1;
      #1 busy0 = busy_o;
      @(negedge clk);
      start_i = 1'b0; exe_cmd_i = '0; val1_i = '0; val2_i = '0; dest_i = '0;
   endtask

   task automatic wait_done(input int first_cyc, output int lat, output logic [31:0] res,
                            output logic [4:0] dout, output logic wb, output int busy_bad,
                            output logic done_after);
      lat = -1; res = '0; dout = '0; wb = 1'b0; busy_bad = 0; done_after = 1'b1;
      for (int c = first_cyc; c < 100; c++) begin
         if (done_o === 1'b1) begin
            lat = c; res = result_o; dout = dest_o; wb = wb_en_o;
            if (busy_o !== 1'b0) busy_bad++;
            break;
         end
         if (busy_o !== 1'b1) busy_bad++;
         @(negedge clk);
      end
      @(negedge clk);
      done_after = done_o;
   endtask

   task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, output int lat, output logic [31:0] res,
                         output logic [4:0] dout, output logic wb, output logic busy0,
                         output int busy_bad, output logic done_after);
      start_op(cmd, a, b, dst, busy0);
      wait_done(1, lat, res, dout, wb, busy_bad, done_after);
   endtask

   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (done_o === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      exe_cmd_i = '0; val1_i = '0; val2_i = '0; dest_i = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", wb_en_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
      checks++; if (dest_o !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d expected 0", dest_o); end
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
   endtask

   task automatic test_mul();
      logic [31:0] t_a [3];
      logic [31:0] t_b [3];
      logic [31:0] t_exp [3];
      int lat, busy_bad;
      logic [31:0] res;
      logic [4:0] dout;
      logic wb, busy0, done_after;
      t_a   = '{32'd7,  32'hFFFF_FFFF, 32'h0001_0000};
      t_b   = '{32'd6,  32'd2,         32'h0001_0003};
      t_exp = '{32'd42, 32'hFFFF_FFFE, 32'h0003_0000};
      for (int i = 0; i < 3; i++) begin
         run_op(EXE_MUL, t_a[i], t_b[i], 5'(i + 5), lat, res, dout, wb, busy0, busy_bad, done_after);
         checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
         checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
         checks++; if (dout !== 5'(i + 5)) begin errors++; $display("FAIL mul_dest[%0d]: got %0d expected %0d", i, dout, i + 5); end
         checks++; if (wb !== 1'b1) begin errors++; $display("FAIL mul_wb_en[%0d]: got %b expected 1", i, wb); end
         checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mul_busy_accept[%0d]: got %b expected 1", i, busy0); end
         checks++; if (busy_bad !== 0) begin errors++; $display("FAIL mul_busy_window[%0d]: got %0d bad cycles expected 0", i, busy_bad); end
         checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL mul_done_pulse[%0d]: got %b expected 0", i, done_after); end
      end
      checks++; if (result_o !== 32'h0003_0000) begin errors++; $display("FAIL mul_result_hold: got %h expected 00030000", result_o); end
      checks++; if (dest_o !== 5'd7) begin errors++; $display("FAIL mul_dest_hold: got %0d expected 7", dest_o); end
   endtask

   task automatic test_div();
      logic [3:0]  t_cmd [5];
      logic [31:0] t_a [5];
      logic [31:0] t_b [5];
      logic [31:0] t_exp [5];
      int lat, busy_bad;
      logic [31:0] res;
      logic [4:0] dout;
      logic wb, busy0, done_after;
      t_cmd = '{EXE_DIV, EXE_REM, EXE_DIV,      EXE_REM, EXE_DIV};
      t_a   = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd7,  32'h8000_0000};
      t_b   = '{32'd7,   32'd7,   32'd1,         32'd100, 32'd3};
      t_exp = '{32'd14,  32'd2,   32'hFFFF_FFFF, 32'd7,  32'h2AAA_AAAA};
      for (int i = 0; i < 5; i++) begin
         run_op(t_cmd[i], t_a[i], t_b[i], 5'(i + 10), lat, res, dout, wb, busy0, busy_bad, done_after);
         checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
         checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
         checks++; if (dout !== 5'(i + 10)) begin errors++; $display("FAIL div_dest[%0d]: got %0d expected %0d", i, dout, i + 10); end
         checks++; if (busy_bad !== 0) begin errors++; $display("FAIL div_busy_window[%0d]: got %0d bad cycles expected 0", i, busy_bad); end
      end
   endtask

   task automatic test_div_zero();
      int lat, busy_bad;
      logic [31:0] res;
      logic [4:0] dout;
      logic wb, busy0, done_after;
      run_op(EXE_DIV, 32'd5, 32'd0, 5'd20, lat, res, dout, wb, busy0, busy_bad, done_after);
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_div_result: got %h expected ffffffff", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL divz_div_latency: got %0d expected 1", lat); end
      checks++; if (dout !== 5'd20) begin errors++; $display("FAIL divz_div_dest: got %0d expected 20", dout); end
      checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL divz_done_pulse: got %b expected 0", done_after); end
      run_op(EXE_REM, 32'd5, 32'd0, 5'd21, lat, res, dout, wb, busy0, busy_bad, done_after);
      checks++; if (res !== 32'd5) begin errors++; $display("FAIL divz_rem_result: got %h expected 5", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL divz_rem_latency: got %0d expected 1", lat); end
      checks++; if (wb !== 1'b1) begin errors++; $display("FAIL divz_rem_wb_en: got %b expected 1", wb); end
   endtask

   task automatic test_ignored_start();
      logic busy0;
      int pulses;
      start_op(4'h3, 32'd9, 32'd9, 5'd1, busy0);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL alu_cmd_busy: got %b expected 0", busy0); end
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL alu_cmd_state: got %0d expected %0d", fsm_state, ST_IDLE); end
      flush_i = 1'b1;
      start_op(EXE_MUL, 32'd9, 32'd9, 5'd1, busy0);
      flush_i = 1'b0;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", busy0); end
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL flush_idle_state: got %0d expected %0d", fsm_state, ST_IDLE); end
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL ignored_done_count: got %0d expected 0", pulses); end
   endtask

   task automatic test_reset_mid();
      logic busy0;
      int pulses;
      start_op(EXE_MUL, 32'd7, 32'd6, 5'd3, busy0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result_o); end
      checks++; if (dest_o !== 5'd0) begin errors++; $display("FAIL rstmid_dest: got %0d expected 0", dest_o); end
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 0", pulses); end
   endtask

   task automatic test_flush_mid();
      logic busy0, wb, done_after;
      int pulses, lat, busy_bad;
      logic [31:0] res;
      logic [4:0] dout;
      start_op(EXE_MUL, 32'h10, 32'h10, 5'd2, busy0);
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL flush_state: got %0d expected %0d", fsm_state, ST_IDLE); end
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_done_count: got %0d expected 0", pulses); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL flush_result_kept: got %h expected 0", result_o); end
      run_op(EXE_MUL, 32'd3, 32'd3, 5'd4, lat, res, dout, wb, busy0, busy_bad, done_after);
      checks++; if (res !== 32'd9) begin errors++; $display("FAIL flush_next_result: got %h expected 9", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL flush_next_latency: got %0d expected 33", lat); end
   endtask

   task automatic test_flush_done();
      logic busy0;
      start_op(EXE_MUL, 32'd5, 32'd5, 5'd6, busy0);
      repeat (31) @(negedge clk);
      @(posedge clk);
      #1 flush_i = 1'b1;
      #1;
      checks++; if (fsm_state !== ST_DONE) begin errors++; $display("FAIL flushdone_state: got %0d expected %0d", fsm_state, ST_DONE); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL flushdone_done: got %b expected 0", done_o); end
      checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL flushdone_wb_en: got %b expected 0", wb_en_o); end
      @(negedge clk);
      flush_i = 1'b0;
      @(negedge clk);
      checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL flushdone_after_state: got %0d expected %0d", fsm_state, ST_IDLE); end
   endtask

   task automatic test_start_during_div();
      logic busy0, busy5, wb, done_after;
      int lat, busy_bad, pulses;
      logic [31:0] res;
      logic [4:0] dout;
      start_op(EXE_DIV, 32'd1000, 32'd10, 5'd3, busy0);
      repeat (4) @(negedge clk);
      start_op(EXE_MUL, 32'd2, 32'd2, 5'd9, busy5);
      checks++; if (busy5 !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b expected 1", busy5); end
      wait_done(6, lat, res, dout, wb, busy_bad, done_after);
      checks++; if (res !== 32'd100) begin errors++; $display("FAIL busy_start_result: got %h expected 64", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
      checks++; if (dout !== 5'd3) begin errors++; $display("FAIL busy_start_dest: got %0d expected 3", dout); end
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL busy_start_extra_done: got %0d expected 0", pulses); end
   endtask

   task automatic test_back_to_back();
      int lat, busy_bad;
      logic [31:0] res;
      logic [4:0] dout;
      logic wb, busy0, done_after;
      run_op(EXE_REM, 32'd1234567, 32'd1000, 5'd30, lat, res, dout, wb, busy0, busy_bad, done_after);
      checks++; if (res !== 32'd567) begin errors++; $display("FAIL b2b_rem_result: got %0d expected 567", res); end
      run_op(EXE_MUL, 32'd1000, 32'd1000, 5'd31, lat, res, dout, wb, busy0, busy_bad, done_after);
      checks++; if (res !== 32'd1000000) begin errors++; $display("FAIL b2b_mul_result: got %0d expected 1000000", res); end
      checks++; if (dout !== 5'd31) begin errors++; $display("FAIL b2b_mul_dest: got %0d expected 31", dout); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_ignored_start();
      test_reset_mid();
      test_flush_mid();
      test_flush_done();
      test_start_during_div();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide engine in the EXE stage. It consumes the ID/EXE pipeline register outputs (EXE_CMD, val1, val2, destination) when the command is MUL, DIV or REM.
- It holds the front of the pipeline with a stall signal while it computes.
- It returns a one-cycle result bundle for the EXE/MEM register.
- It is the consuming end of the ID/EXE interface, with a back-pressure path to hazard control.

Parameters:
- WIDTH, 32: operand and result width; must match the datapath word length.
- FUNC_W, 4: width of the execute command field.
- REG_W, 5: destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  ID/EXE entry is valid and carries a MUL/DIV/REM command.
- exe_cmd_i  in  FUNC_W  command from the ID/EXE register.
- val1_i  in  WIDTH  operand A (multiplicand or dividend).
- val2_i  in  WIDTH  operand B (multiplier or divisor).
- dest_i  in  REG_W  destination register.
- flush_i  in  1  abort the operation in flight (branch taken).
- busy_o  out  1  stall request to PC, IF/ID and ID/EXE (hold).
- done_o  out  1  one-cycle pulse; result_o, dest_o and wb_en_o are valid.
- result_o  out  WIDTH  product low word, quotient, or remainder.
- dest_o  out  REG_W  latched destination.
- wb_en_o  out  1  write-back enable, equal to done_o.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy_o=0, done_o=0, wb_en_o=0, result_o=0, dest_o=0.
  - Internal accumulator, quotient, remainder and count registers are cleared.
  - Reset has priority over flush_i and start_i.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start_i with cmd MUL: latch the operands, dest_i and cmd; count=0; go to MUL.
  - On start_i with cmd DIV or REM and val2_i!=0: latch; go to DIV.
  - On start_i with cmd DIV or REM and val2_i==0: go directly to DONE.
    - DIV result = all ones.
    - REM result = val1_i.
  - start_i with any other cmd is ignored.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle, LSB first.
  - Runs for WIDTH cycles, then goes to DONE.
  - Result is the low WIDTH bits of the product; overflow bits are discarded.
- DIV:
  - Unsigned restoring division, one quotient bit per cycle, MSB first.
  - Runs for WIDTH cycles, then goes to DONE.
  - DIV selects the quotient, REM selects the remainder.
- DONE: done_o=1 and wb_en_o=1 for exactly one cycle, then go to IDLE. result_o and dest_o hold until the next completion.
- busy_o (combinational):
  - 1 when state is MUL or DIV.
  - 1 when state is IDLE and start_i is asserted with an accepted command (same-cycle freeze).
  - 0 in DONE, so the held instruction advances as the result retires.
- Latency:
  - Acceptance is cycle 0; done_o is asserted at cycle WIDTH+1.
  - Divide-by-zero: done_o is asserted at cycle 1.
- start_i while not IDLE is ignored; upstream is already stalled.
- flush_i:
  - In MUL or DIV: go to IDLE next cycle with no done_o pulse; busy_o=0 from that cycle on.
  - In DONE: done_o is suppressed.
  - In IDLE: also blocks acceptance that cycle.
- Reset mid-operation behaves like flush_i and also clears the outputs.
- Counter is log2(WIDTH)+1 bits wide and must not wrap before the terminal compare.

Decomposition:
- Add to the shared defines file:
  - EXE_CMD encodings for MUL, DIV and REM, distinct from the existing ALU codes.
  - The state encoding constants.
- One natural sub-module, muldiv_datapath:
  - Contains the shift registers, the adder/subtractor and the counter.
  - Driven by load/step/select controls from the FSM in exe_muldiv_unit.

Test Plan (WIDTH=32):
- MUL 7 x 6, start_i for 1 cycle -> busy_o=1 at cycles 0..32, done_o at cycle 33, result_o=42, dest_o=dest_i, wb_en_o=1 for 1 cycle.
- MUL 0xFFFFFFFF x 2 -> result_o=0xFFFFFFFE (low word only).
- DIV 100/7 -> result_o=14; REM 100/7 -> result_o=2; each done_o at cycle 33.
- DIV 5/0 -> result_o=0xFFFFFFFF, done_o at cycle 1; REM 5/0 -> result_o=5.
- Flush or reset mid-operation:
  - Start MUL, then assert reset at cycle 10 -> busy_o=0 at cycle 11, no done_o, result_o=0.
  - Repeat with flush_i -> no done_o, and a new MUL 3x3 accepted afterwards gives 9.
- Start DIV, then pulse start_i with MUL at cycle 5 -> the MUL is ignored, and the DIV result is correct at cycle 33.
